meteo_channel_sequencer: RTL and testbench
==========================================

# meteo_channel_sequencer

Parametrised display sequencer for the meteo station top level. It takes NUM_CH binary sensor words (temperature, pressure, humidity, and any later additions). It selects one channel, either manually with a one-hot select or automatically with a dwell timer. It converts the selected word to BCD with an iterative shift-add-3 engine and drives NUM_DIGITS active-low 7-segment displays on the DE0-CV. It replaces the fixed 3-way select/decoder path between the compensation logic and the HEX outputs.

## Interface
Parameters:
- NUM_CH, 3: number of input channels (2..8).
- DATA_W, 20: width of each unsigned channel word (4..32).
- NUM_DIGITS, 6: number of 7-segment digits (1..8).
- DWELL_CYCLES, 50_000_000: auto-scroll dwell per channel, in Clk_i cycles (≥ DATA_W+4).

Ports:
- Clk_i  in  1  system clock; single clock domain.
- Rst_i  in  1  synchronous, active-high reset.
- ChData_i  in  NUM_CH*DATA_W  channel words; channel k occupies bits [k*DATA_W +: DATA_W].
- ChValid_i  in  NUM_CH  one-cycle pulse per channel when a new sample is present.
- Sel_i  in  NUM_CH  one-hot manual select; bit k selects channel k.
- AutoScroll_i  in  1  1 = rotate channels on the dwell timer; Sel_i is ignored.
- Seg_o  out  NUM_DIGITS*7  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 (least significant) in bits [6:0].
- ChIdx_o  out  $clog2(NUM_CH)  index of the channel currently shown.
- Busy_o  out  1  conversion in progress.
- Overflow_o  out  1  shown value does not fit in NUM_DIGITS decimal digits.
- ErrFlag_o  out  1  Sel_i is not one-hot while in manual mode.

## Operation
- Channel selection, manual mode: a one-hot Sel_i sets the channel index. Zero bits or more than one bit set: index holds and ErrFlag_o = 1. ErrFlag_o is 0 whenever Sel_i is valid or AutoScroll_i = 1.
- Channel selection, auto mode: the dwell counter counts 0..DWELL_CYCLES-1. At terminal count the index increments modulo NUM_CH (NUM_CH-1 wraps to 0) and the counter clears.
  - The counter clears whenever AutoScroll_i is 0.
  - Entering auto mode keeps the current index.
- Conversion trigger: any of
  - an index change;
  - ChValid_i[index] = 1;
  - the first cycle after reset deasserts.
- FSM states:
  - IDLE: on trigger, latch ChData_i[index] into the shift register and go to SHIFT.
  - SHIFT: DATA_W iterations. Each adds 3 to every BCD nibble ≥ 5, then shifts left 1. Then go to DONE.
  - DONE: copy the BCD and overflow result into the display register in one cycle, then return to IDLE.
- Trigger while in SHIFT or DONE: set a single pending flag; further triggers merge into it. On leaving DONE with pending set, go straight to the load and clear the flag. The value latched is the one current at that load.
- Overflow: at load, compare the value against 10^NUM_DIGITS. If value ≥ 10^NUM_DIGITS:
  - every digit shows dash (segment g only lit, 7'b0111111);
  - Overflow_o = 1.
- Segment decode: digits 0-9 use standard active-low patterns (0 = 7'b1000000). Blank = 7'b1111111.
- Seg_o, Overflow_o and ChIdx_o change only in DONE, so the display never shows a partially converted value. ChIdx_o reports the channel of the displayed value.

## Timing
- Reset values:
  - Seg_o: all digits show "0", or digit 0 = "0" and others blank with METEO_LZB_EN.
  - ChIdx_o = 0, Busy_o = 0, Overflow_o = 0, ErrFlag_o = 0.
  - Dwell counter, pending flag and FSM cleared.
- Reset mid-conversion aborts it and returns to the reset values.
- Latency: trigger at cycle T means load at T+1 and Seg_o updated at T+DATA_W+2, so the total is DATA_W+2 cycles.
- Busy_o is high from the load cycle through DONE inclusive.
- ErrFlag_o is registered, 1 cycle after Sel_i.
- A dwell terminal count and a ChValid_i pulse in the same cycle give one trigger, for the new index.

## Configuration
- METEO_LZB_EN defined: leading-zero blanking. Every zero digit above the most significant nonzero digit is blank; digit 0 is never blanked. Overflow dashes are unaffected.
- Not defined: all NUM_DIGITS digits are always driven, with leading zeros shown.

## Test plan
- Reset, then Sel_i = 3'b001 with ch0 = 12345 and a ChValid_i[0] pulse → after 22 cycles Seg_o shows 012345 (or blank,1,2,3,4,5 with LZB), ChIdx_o = 0, Overflow_o = 0.
- Sel_i = 3'b010 with ch1 = 20'hFFFFF (1048575) → all six digits dash, Overflow_o = 1; then ch1 = 999999 with a pulse → 999999 shown, Overflow_o = 0.
- Sel_i = 3'b011, then 3'b000 → index holds at 1, ErrFlag_o = 1 one cycle later; Sel_i = 3'b100 → index 2, ErrFlag_o = 0.
- AutoScroll_i = 1 with DWELL_CYCLES = 100 → ChIdx_o sequence 0,1,2,0 with updates spaced 100 cycles (+22 latency); the 2→0 wrap is checked.
- ChValid_i pulses on the shown channel at load+3, load+5 and load+7 → exactly one extra conversion, which uses the data present at its load.
- Rst_i asserted at SHIFT iteration 10 → next cycle all outputs at reset values; after release, channel 0 is reconverted automatically.

Source files
------------

// File: rtl/meteo_channel_sequencer.sv
// meteo_channel_sequencer: selects one of NUM_CH sensor words (manual one-hot
// select or timed auto-scroll), converts it to BCD with an iterative
// shift-add-3 engine and drives NUM_DIGITS active-low 7-segment digits.
// Optional build macro: METEO_LZB_EN enables leading-zero blanking.
module meteo_channel_sequencer #(
    parameter int NUM_CH       = 3,
    parameter int DATA_W       = 20,
    parameter int NUM_DIGITS   = 6,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                        Clk_i,
    input  logic                        Rst_i,
    input  logic [NUM_CH*DATA_W-1:0]    ChData_i,
    input  logic [NUM_CH-1:0]           ChValid_i,
    input  logic [NUM_CH-1:0]           Sel_i,
    input  logic                        AutoScroll_i,
    output logic [NUM_DIGITS*7-1:0]     Seg_o,
    output logic [$clog2(NUM_CH)-1:0]   ChIdx_o,
    output logic                        Busy_o,
    output logic                        Overflow_o,
    output logic                        ErrFlag_o
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(DWELL_CYCLES);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DATA_W - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Smallest value that no longer fits in the display.
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add 3 to every nibble >= 5 ahead of the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
        end
        return r;
    endfunction

    // Full display image for a BCD value; overflow turns every digit into a dash.
    function automatic logic [NUM_DIGITS*7-1:0] disp_of(input logic [BCD_W-1:0] b,
                                                        input logic ovf);
        logic [NUM_DIGITS*7-1:0] s;
        logic seen;
        s    = {(NUM_DIGITS*7){1'b1}};
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen = seen | (b[4*i +: 4] != 4'd0) | (i == 0);
            if (ovf) begin
                s[7*i +: 7] = 7'b0111111;
`ifdef METEO_LZB_EN
            end else if (!seen) begin
                s[7*i +: 7] = 7'b1111111;
`endif
            end else begin
                s[7*i +: 7] = seg7(b[4*i +: 4]);
            end
        end
        return s;
    endfunction

    state_t                  state_r, state_nx_s;
    logic [IDX_W-1:0]        idx_r, idx_nx_s, sel_pos_s, conv_idx_r, shown_idx_r;
    logic [3:0]              sel_ones_s;
    logic                    sel_ok_s, valid_cur_s, trigger_s, load_s;
    logic                    pend_r, pend_nx_s, first_r, err_r, busy_r;
    logic                    ovf_r, ovf_disp_r;
    logic [CNT_W-1:0]        dwell_r;
    logic [DATA_W-1:0]       load_data_s, bin_r;
    logic [BCD_W-1:0]        bcd_r;
    logic [ITER_W-1:0]       iter_r;
    logic [NUM_DIGITS*7-1:0] seg_r;

    // Channel selection: decode Sel_i, advance on dwell terminal count, pick load data.
    always_comb begin
        sel_ones_s  = 4'd0;
        sel_pos_s   = {IDX_W{1'b0}};
        valid_cur_s = 1'b0;
        load_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            sel_ones_s  = sel_ones_s + 4'(Sel_i[k]);
            sel_pos_s   = Sel_i[k] ? IDX_W'(k) : sel_pos_s;
            valid_cur_s = (IDX_W'(k) == idx_r) ? ChValid_i[k] : valid_cur_s;
        end
        sel_ok_s = (sel_ones_s == 4'd1);
        if (AutoScroll_i) begin
            if (dwell_r == LAST_CNT) begin
                idx_nx_s = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (idx_r + {{(IDX_W-1){1'b0}}, 1'b1});
            end else begin
                idx_nx_s = idx_r;
            end
        end else if (sel_ok_s) begin
            idx_nx_s = sel_pos_s;
        end else begin
            idx_nx_s = idx_r;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            load_data_s = (IDX_W'(k) == idx_nx_s) ? ChData_i[k*DATA_W +: DATA_W] : load_data_s;
        end
        trigger_s = first_r | valid_cur_s | (idx_nx_s != idx_r);
    end

    // Conversion FSM next-state and load decision; triggers while busy merge into pend.
    always_comb begin
        state_nx_s = state_r;
        pend_nx_s  = pend_r;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                pend_nx_s = pend_r | trigger_s;
                if (iter_r == LAST_ITER) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                pend_nx_s = 1'b0;
                if (pend_r | trigger_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                pend_nx_s  = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) state_r <= ST_IDLE;
        else       state_r <= state_nx_s;
    end

    // Selection, dwell timer, shift-add-3 datapath and registered display outputs.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            idx_r       <= {IDX_W{1'b0}};
            dwell_r     <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            first_r     <= 1'b1;
            pend_r      <= 1'b0;
            busy_r      <= 1'b0;
            bin_r       <= {DATA_W{1'b0}};
            bcd_r       <= {BCD_W{1'b0}};
            iter_r      <= {ITER_W{1'b0}};
            ovf_r       <= 1'b0;
            conv_idx_r  <= {IDX_W{1'b0}};
            seg_r       <= disp_of({BCD_W{1'b0}}, 1'b0);
            ovf_disp_r  <= 1'b0;
            shown_idx_r <= {IDX_W{1'b0}};
        end else begin
            idx_r   <= idx_nx_s;
            err_r   <= ~AutoScroll_i & ~sel_ok_s;
            first_r <= 1'b0;
            pend_r  <= pend_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            if (!AutoScroll_i || dwell_r == LAST_CNT) dwell_r <= {CNT_W{1'b0}};
            else                                      dwell_r <= dwell_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (load_s) begin
                bin_r      <= load_data_s;
                bcd_r      <= {BCD_W{1'b0}};
                iter_r     <= {ITER_W{1'b0}};
                ovf_r      <= ({{(64-DATA_W){1'b0}}, load_data_s} >= LIMIT);
                conv_idx_r <= idx_nx_s;
            end else if (state_r == ST_SHIFT) begin
                bcd_r  <= {bcd_adjust(bcd_r), bin_r[DATA_W-1]} [BCD_W-1:0];
                bin_r  <= {bin_r[DATA_W-2:0], 1'b0};
                iter_r <= iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
            end
            if (state_r == ST_DONE) begin
                seg_r       <= disp_of(bcd_r, ovf_r);
                ovf_disp_r  <= ovf_r;
                shown_idx_r <= conv_idx_r;
            end
        end
    end

    assign Seg_o      = seg_r;
    assign ChIdx_o    = shown_idx_r;
    assign Busy_o     = busy_r;
    assign Overflow_o = ovf_disp_r;
    assign ErrFlag_o  = err_r;

endmodule

// File: tb/tb_meteo_channel_sequencer.sv
// Directed + randomized bench for meteo_channel_sequencer (3 ch, 20-bit, 6 digits,
// dwell 100). Expected displays come from decimal arithmetic on the sample value.
module tb_meteo_channel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [59:0] ch_data;
    logic [2:0]  ch_valid;
    logic [2:0]  sel;
    logic        auto_scroll;
    logic [41:0] seg;
    logic [1:0]  ch_idx;
    logic        busy, ovf, err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [41:0] shown_seg;

    localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    meteo_channel_sequencer #(
        .NUM_CH(3), .DATA_W(20), .NUM_DIGITS(6), .DWELL_CYCLES(100)
    ) dut (
        .Clk_i(clk), .Rst_i(rst), .ChData_i(ch_data), .ChValid_i(ch_valid),
        .Sel_i(sel), .AutoScroll_i(auto_scroll), .Seg_o(seg), .ChIdx_o(ch_idx),
        .Busy_o(busy), .Overflow_o(ovf), .ErrFlag_o(err)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Expected display image: dashes at or above 10^6, else the decimal digits.
    function automatic logic [41:0] exp_seg(input logic [19:0] v);
        logic [41:0] s;
        longint lv, p;
        lv = {44'd0, v};
        p  = 1;
        for (int i = 0; i < 6; i++) begin
            if (lv >= 1000000) begin
                s[7*i +: 7] = 7'b0111111;
`ifdef METEO_LZB_EN
            end else if (i > 0 && lv < p) begin
                s[7*i +: 7] = 7'b1111111;
`endif
            end else begin
                s[7*i +: 7] = SEG_TBL[int'((lv / p) % 10)];
            end
            p = p * 10;
        end
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [19:0] v);
        ch_data[ch*20 +: 20] = v;
    endtask

    // Called in the trigger cycle T; follows the conversion to its display at T+22.
    task automatic expect_conv(input string tag, input logic [19:0] v, input int ch);
        tick(1);
        ch_valid = 3'b000;
        chk({tag, "_busy_load"}, 64'(busy), 64'd1);
        tick(20);
        chk({tag, "_seg_hold"}, 64'(seg), 64'(shown_seg));
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        tick(1);
        chk({tag, "_seg"}, 64'(seg), 64'(exp_seg(v)));
        chk({tag, "_idx"}, 64'(ch_idx), 64'(ch));
        chk({tag, "_ovf"}, 64'(ovf), (v >= 20'd1000000) ? 64'd1 : 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        shown_seg = exp_seg(v);
    endtask

    initial begin
        logic [19:0] v, v1, v2;
        int          busy_hits;
        int          cur_ch;
        int          ch;

        rst = 1'b1; ch_data = 60'd0; ch_valid = 3'b000; sel = 3'b001; auto_scroll = 1'b0;
        shown_seg = exp_seg(20'd0);
        tick(3);
        chk("rst_seg", 64'(seg), 64'(exp_seg(20'd0)));
        chk("rst_idx", 64'(ch_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // First cycle after reset converts the selected channel by itself.
        v = 20'($urandom_range(1, 999999));
        set_ch(0, v);
        rst = 1'b0;
        expect_conv("post_rst", v, 0);

        set_ch(0, 20'd12345); ch_valid = 3'b001;
        expect_conv("ch0_12345", 20'd12345, 0);
        set_ch(0, 20'd1000000); ch_valid = 3'b001;
        expect_conv("ch0_limit", 20'd1000000, 0);

        set_ch(1, 20'hFFFFF); sel = 3'b010;
        expect_conv("ch1_max", 20'hFFFFF, 1);
        set_ch(1, 20'd999999); ch_valid = 3'b010;
        expect_conv("ch1_999999", 20'd999999, 1);

        // Invalid selects hold the index and flag one cycle later.
        sel = 3'b011;
        chk("err_before", 64'(err), 64'd0);
        tick(1);
        chk("err_two_hot", 64'(err), 64'd1);
        chk("hold_idx_a", 64'(ch_idx), 64'd1);
        chk("hold_busy_a", 64'(busy), 64'd0);
        sel = 3'b000;
        tick(1);
        chk("err_zero_hot", 64'(err), 64'd1);
        chk("hold_busy_b", 64'(busy), 64'd0);
        v = 20'($urandom_range(0, 999999));
        set_ch(2, v); sel = 3'b100;
        expect_conv("ch2_sel", v, 2);
        chk("err_clear", 64'(err), 64'd0);

        // Pulses during a conversion merge into exactly one follow-up conversion.
        v1 = 20'($urandom_range(0, 999998));
        v2 = v1 ^ 20'd1;
        set_ch(2, v1); ch_valid = 3'b100;
        tick(1); ch_valid = 3'b000;
        tick(3); ch_valid = 3'b100;
        tick(1); ch_valid = 3'b000;
        tick(1); ch_valid = 3'b100;
        tick(1); ch_valid = 3'b000;
        tick(1); ch_valid = 3'b100;
        tick(1); ch_valid = 3'b000;
        tick(2); set_ch(2, v2);
        tick(11);
        chk("pend_first_seg", 64'(seg), 64'(exp_seg(v1)));
        chk("pend_busy_cont", 64'(busy), 64'd1);
        tick(20);
        chk("pend_seg_hold", 64'(seg), 64'(exp_seg(v1)));
        tick(1);
        chk("pend_second_seg", 64'(seg), 64'(exp_seg(v2)));
        chk("pend_idle", 64'(busy), 64'd0);
        shown_seg = exp_seg(v2);
        busy_hits = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy) busy_hits++;
        end
        chk("pend_no_third", 64'(busy_hits), 64'd0);

        // Auto-scroll from channel 0: 0 -> 1 -> 2 -> 0 every 100 cycles.
        v = 20'($urandom_range(1000000, 1048575));
        set_ch(0, v); sel = 3'b001;
        expect_conv("auto_prep", v, 0);
        v1 = 20'($urandom_range(0, 999999));
        v2 = 20'($urandom_range(0, 999999));
        set_ch(1, v1); set_ch(2, v2);
        auto_scroll = 1'b1; sel = 3'b000;
        tick(120);
        chk("auto_idx0", 64'(ch_idx), 64'd0);
        chk("auto_err", 64'(err), 64'd0);
        tick(1);
        chk("auto_idx1", 64'(ch_idx), 64'd1);
        chk("auto_seg1", 64'(seg), 64'(exp_seg(v1)));
        tick(99);
        chk("auto_hold1", 64'(ch_idx), 64'd1);
        tick(1);
        chk("auto_idx2", 64'(ch_idx), 64'd2);
        chk("auto_seg2", 64'(seg), 64'(exp_seg(v2)));
        tick(99);
        chk("auto_hold2", 64'(ch_idx), 64'd2);
        tick(1);
        chk("auto_wrap", 64'(ch_idx), 64'd0);
        chk("auto_seg0", 64'(seg), 64'(exp_seg(v)));
        chk("auto_ovf0", 64'(ovf), 64'd1);
        shown_seg = exp_seg(v);

        // Reset in the middle of a conversion, then automatic reconversion of ch0.
        tick(1);
        auto_scroll = 1'b0; sel = 3'b010; set_ch(1, 20'hFFFFF);
        expect_conv("rst_prep", 20'hFFFFF, 1);
        set_ch(1, 20'($urandom_range(0, 999999))); ch_valid = 3'b010;
        tick(1); ch_valid = 3'b000;
        tick(10);
        rst = 1'b1; sel = 3'b001;
        v = 20'($urandom_range(1, 999999));
        set_ch(0, v);
        tick(1);
        chk("mid_rst_seg", 64'(seg), 64'(exp_seg(20'd0)));
        chk("mid_rst_idx", 64'(ch_idx), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        shown_seg = exp_seg(20'd0);
        rst = 1'b0;
        expect_conv("rst_reconv", v, 0);

        // Random manual traffic: select changes and valid pulses.
        cur_ch = 0;
        for (int it = 0; it < 8; it++) begin
            ch = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) v = 20'($urandom_range(0, 999999));
            else                           v = 20'($urandom_range(0, 1048575));
            set_ch(ch, v);
            if (ch != cur_ch) sel = 3'(1 << ch);
            else              ch_valid = 3'(1 << ch);
            cur_ch = ch;
            expect_conv($sformatf("rand%0d", it), v, ch);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
